// File: rtl/blur_scan_ctrl_if.sv
// Handshake and memory-address bundle between the blur scan sequencer and
// the filter / window-average side.
interface blur_scan_ctrl_if #(
  parameter int addr_w = 8
);
  logic              ST;
  logic              RD;
  logic              DONE;
  logic [addr_w-1:0] ADDR1;
  logic [addr_w-1:0] ADDR2;
  logic [addr_w-1:0] ADDR3;
  logic              Read;
  logic [addr_w-1:0] ADDRO;
  logic              WR;
  logic              HREQ;
  logic              HGNT;
  logic [15:0]       PIXCNT;

  // Handshakes: ST is a single-cycle request acknowledged only while RD is high;
  // HREQ is a level request held by the host until it has finished, and HGNT
  // stays high exactly for as long as the memories belong to the host.
  modport master (
    input  ST, HREQ,
    output RD, DONE, ADDR1, ADDR2, ADDR3, Read, ADDRO, WR, HGNT, PIXCNT
  );

  modport slave (
    output ST, HREQ,
    input  RD, DONE, ADDR1, ADDR2, ADDR3, Read, ADDRO, WR, HGNT, PIXCNT
  );
endinterface

// File: rtl/blur_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 box blur: walks every interior pixel,
// issues the three row reads, waits out read latency, then strobes the write.
module blur_scan_ctrl #(
  parameter int imW    = 16,
  parameter int imH    = 16,
  parameter int addr_w = 8,
  parameter int RLAT   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  blur_scan_ctrl_if.master bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOST  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [addr_w-1:0] W_A    = addr_w'(imW);
  localparam logic [addr_w-1:0] J_LAST = addr_w'(imW - 2);
  localparam logic [addr_w-1:0] I_LAST = addr_w'(imH - 2);
  localparam logic [addr_w-1:0] ONE_A  = addr_w'(1);
  localparam logic [15:0]       W_LAST = 16'(RLAT - 1);

  state_t            state_q, state_d;
  logic [addr_w-1:0] i_q, i_d, j_q, j_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [15:0]       pix_q;
  logic [addr_w-1:0] a1_q, a2_q, a3_q, ao_q;
  logic [addr_w-1:0] row_d, a1_d, a2_d, a3_d, ao_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ST) begin
          state_d = S_ISSUE;
          i_d     = ONE_A;
          j_d     = ONE_A;
        end else if (bus.HREQ) begin
          state_d = S_HOST;
        end
      end
      S_HOST: begin
        if (!bus.HREQ) state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (RLAT == 1) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      S_WAIT: begin
        if (wcnt_q >= W_LAST) state_d = S_WRITE;
        else                  wcnt_d  = wcnt_q + 16'd1;
      end
      S_WRITE: begin
        if (j_q < J_LAST) begin
          j_d     = j_q + ONE_A;
          state_d = S_ISSUE;
        end else if (i_q < I_LAST) begin
          j_d     = ONE_A;
          i_d     = i_q + ONE_A;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window addresses are formed from the next (i, j) so they are already
  // valid in the first ISSUE cycle and held through WAIT and WRITE.
  always_comb begin
    row_d = i_d * W_A;
    a2_d  = row_d + j_d - ONE_A;
    a1_d  = a2_d - W_A;
    a3_d  = a2_d + W_A;
    ao_d  = row_d + j_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      i_q     <= ONE_A;
      j_q     <= ONE_A;
      wcnt_q  <= 16'd0;
      pix_q   <= 16'd0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      ao_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wcnt_q  <= wcnt_d;
      if (state_q == S_IDLE && bus.ST) pix_q <= 16'd0;
      else if (state_q == S_WRITE)     pix_q <= pix_q + 16'd1;
      if (state_d == S_ISSUE) begin
        a1_q <= a1_d;
        a2_q <= a2_d;
        a3_q <= a3_d;
        ao_q <= ao_d;
      end
    end
  end

  always_comb begin
    bus.RD     = (state_q == S_IDLE);
    bus.HGNT   = (state_q == S_HOST);
    bus.Read   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    bus.WR     = (state_q == S_WRITE);
    bus.DONE   = (state_q == S_FIN);
    bus.ADDR1  = a1_q;
    bus.ADDR2  = a2_q;
    bus.ADDR3  = a3_q;
    bus.ADDRO  = ao_q;
    bus.PIXCNT = pix_q;
    dbg_state  = state_q;
  end

endmodule
